// File: rtl/sw_reg_pkg.sv
// Shared constants and address-decode helpers for the software register bank.
//   SW_REG_DW  : register / data width in bits
//   SW_REG_BE  : number of byte lanes
//   sw_reg_idx : word index of a byte address relative to the bank base
//   sw_reg_hit : address lies inside [base, high] and maps to an existing register
package sw_reg_pkg;

    localparam int unsigned SW_REG_DW = 32;
    localparam int unsigned SW_REG_BE = 4;

    // Word index; adr[1:0] is dropped.
    function automatic logic [31:0] sw_reg_idx(input logic [31:0] adr,
                                               input logic [31:0] base);
        logic [31:0] off;
        off = adr - base;
        return {2'b00, off[31:2]};
    endfunction

    // The index is only meaningful once the range check has passed.
    function automatic logic sw_reg_hit(input logic [31:0]  adr,
                                        input logic [31:0]  base,
                                        input logic [31:0]  high,
                                        input int unsigned  nregs);
        return (adr >= base) && (adr <= high) && (sw_reg_idx(adr, base) < 32'(nregs));
    endfunction

endpackage

// File: rtl/sw_reg_cell.sv
// One 32-bit read/write register with byte-lane write enables and a write strobe.
//   clk, rst  : clock, synchronous active-high reset
//   wr_en     : write this register this cycle
//   sel       : byte lane enables for the write
//   wdata     : write data
//   q         : current register value
//   wr_stb    : one-cycle pulse following every write, even when sel is all zero
module sw_reg_cell
    import sw_reg_pkg::*;
#(
    parameter logic [SW_REG_DW-1:0] C_RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [SW_REG_BE-1:0] sel,
    input  logic [SW_REG_DW-1:0] wdata,
    output logic [SW_REG_DW-1:0] q,
    output logic                 wr_stb
);

    // Byte-merge write; strobe tracks the write request itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            q      <= C_RESET_VAL;
            wr_stb <= 1'b0;
        end else begin
            wr_stb <= wr_en;
            if (wr_en) begin
                for (int unsigned k = 0; k < SW_REG_BE; k++) begin
                    if (sel[k]) begin
                        q[8*k +: 8] <= wdata[8*k +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sw_reg_bank.sv
// Bank of C_NUM_REGS 32-bit software registers on a Wishbone classic slave port.
// Each register is read-only (captured from the fabric every clock) or read/write
// (bus-written, driven to the fabric with a write strobe), chosen by C_RO_MASK.
// Optional feature macro: SW_REG_BANK_ERR_EN -- when defined, writes to read-only
// registers and out-of-range accesses end with wb_err_o instead of wb_ack_o.
// Ports:
//   wb_clk_i, wb_rst_i   : clock, synchronous active-high reset
//   wb_cyc_i, wb_stb_i   : bus cycle / strobe
//   wb_we_i, wb_sel_i    : write enable, byte lanes
//   wb_adr_i, wb_dat_i   : byte address, write data
//   wb_dat_o             : read data, non-zero only during a read ack
//   wb_ack_o, wb_err_o   : one-cycle termination pulses
//   fabric_data_in       : per-register capture inputs (read-only lanes only)
//   fabric_data_out      : read/write register values, zero on read-only lanes
//   fabric_wr_stb        : per-register write pulse
module sw_reg_bank
    import sw_reg_pkg::*;
#(
    parameter logic [31:0]           C_BASEADDR  = 32'h0000_0000,
    parameter logic [31:0]           C_HIGHADDR  = 32'h0000_FFFF,
    parameter int unsigned           C_NUM_REGS  = 8,
    parameter logic [C_NUM_REGS-1:0] C_RO_MASK   = 8'h0F,
    parameter logic [31:0]           C_RESET_VAL = 32'h0000_0000
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,
    input  logic                            wb_cyc_i,
    input  logic                            wb_stb_i,
    input  logic                            wb_we_i,
    input  logic [SW_REG_BE-1:0]            wb_sel_i,
    input  logic [31:0]                     wb_adr_i,
    input  logic [SW_REG_DW-1:0]            wb_dat_i,
    output logic [SW_REG_DW-1:0]            wb_dat_o,
    output logic                            wb_ack_o,
    output logic                            wb_err_o,
    input  logic [SW_REG_DW*C_NUM_REGS-1:0] fabric_data_in,
    output logic [SW_REG_DW*C_NUM_REGS-1:0] fabric_data_out,
    output logic [C_NUM_REGS-1:0]           fabric_wr_stb
);

`ifdef SW_REG_BANK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic                  req_c;
    logic                  hit_c;
    logic                  ro_c;
    logic                  bad_c;
    logic                  wr_req_c;
    logic [31:0]           idx_c;
    logic [SW_REG_DW-1:0]  rd_val_c;
    logic [C_NUM_REGS-1:0] cell_we_c;
    logic [SW_REG_DW-1:0]  reg_val [C_NUM_REGS];

    // A new request is accepted only while no termination is being presented.
    assign req_c    = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign idx_c    = sw_reg_idx(wb_adr_i, C_BASEADDR);
    assign hit_c    = sw_reg_hit(wb_adr_i, C_BASEADDR, C_HIGHADDR, C_NUM_REGS);
    assign wr_req_c = req_c & wb_we_i & hit_c;
    assign bad_c    = ~hit_c | (wb_we_i & ro_c);

    // Register select: read mux, read-only flag and per-cell write enables.
    always_comb begin
        ro_c      = 1'b0;
        rd_val_c  = '0;
        cell_we_c = '0;
        for (int unsigned i = 0; i < C_NUM_REGS; i++) begin
            if (idx_c == 32'(i)) begin
                ro_c         = C_RO_MASK[i];
                rd_val_c     = reg_val[i];
                cell_we_c[i] = wr_req_c & ~C_RO_MASK[i];
            end
        end
    end

    // Termination and read data; a request coinciding with reset is dropped.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= req_c & ~(ERR_EN & bad_c);
            wb_err_o <= req_c & ERR_EN & bad_c;
            wb_dat_o <= (req_c & ~wb_we_i & hit_c) ? rd_val_c : '0;
        end
    end

    // Per-register storage: capture flop for read-only lanes, RW cell otherwise.
    for (genvar i = 0; i < int'(C_NUM_REGS); i++) begin : g_reg
        if (C_RO_MASK[i]) begin : g_ro
            logic [SW_REG_DW-1:0] cap_q;
            logic                 unused_we;

            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    cap_q <= '0;
                end else begin
                    cap_q <= fabric_data_in[SW_REG_DW*i +: SW_REG_DW];
                end
            end

            assign unused_we                                   = cell_we_c[i];
            assign reg_val[i]                                  = cap_q;
            assign fabric_data_out[SW_REG_DW*i +: SW_REG_DW]   = '0;
            assign fabric_wr_stb[i]                            = 1'b0;
        end else begin : g_rw
            logic [SW_REG_DW-1:0] cell_q;
            logic                 cell_stb;
            logic                 unused_fabric_in;

            sw_reg_cell #(
                .C_RESET_VAL (C_RESET_VAL)
            ) u_cell (
                .clk    (wb_clk_i),
                .rst    (wb_rst_i),
                .wr_en  (cell_we_c[i]),
                .sel    (wb_sel_i),
                .wdata  (wb_dat_i),
                .q      (cell_q),
                .wr_stb (cell_stb)
            );

            assign unused_fabric_in                            = ^fabric_data_in[SW_REG_DW*i +: SW_REG_DW];
            assign reg_val[i]                                  = cell_q;
            assign fabric_data_out[SW_REG_DW*i +: SW_REG_DW]   = cell_q;
            assign fabric_wr_stb[i]                            = cell_stb;
        end
    end

endmodule

// File: tb/tb_sw_reg_bank.sv
// Self-checking bench for sw_reg_bank with default parameters
// (8 regs, regs 0..3 read-only, regs 4..7 read/write, reset value 0).
module tb_sw_reg_bank;

    localparam int unsigned NREGS = 8;
    localparam int unsigned BW    = 32 * NREGS;

`ifdef SW_REG_BANK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            cyc;
    logic            stb;
    logic            we;
    logic [3:0]      sel;
    logic [31:0]     adr;
    logic [31:0]     wdat;
    logic [31:0]     rdat;
    logic            ack;
    logic            err;
    logic [BW-1:0]   fab_in;
    logic [BW-1:0]   fab_out;
    logic [NREGS-1:0] fab_stb;

    always #5 clk = ~clk;

    sw_reg_bank dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .wb_cyc_i        (cyc),
        .wb_stb_i        (stb),
        .wb_we_i         (we),
        .wb_sel_i        (sel),
        .wb_adr_i        (adr),
        .wb_dat_i        (wdat),
        .wb_dat_o        (rdat),
        .wb_ack_o        (ack),
        .wb_err_o        (err),
        .fabric_data_in  (fab_in),
        .fabric_data_out (fab_out),
        .fabric_wr_stb   (fab_stb)
    );

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [7:0]  exp_stb;
        int          lane;       // lane whose value is checked; -1 = whole fabric unchanged
        logic [31:0] exp_lane;
    } vec_t;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic        chk_dat;
        logic [31:0] dat;
        logic [7:0]  stb;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[15];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [3:0] s, input logic [31:0] a,
                                input logic [31:0] d, input logic ea, input logic ee,
                                input logic [31:0] er, input logic [7:0] es,
                                input int ln, input logic [31:0] el);
        vec_t v;
        v.we = w; v.sel = s; v.adr = a; v.dat = d;
        v.exp_ack = ea; v.exp_err = ee; v.exp_rd = er; v.exp_stb = es;
        v.lane = ln; v.exp_lane = el;
        return v;
    endfunction

    // One single-beat access: push expectation on drive, pop and compare on termination.
    task automatic run_vec(input vec_t v, input string tag);
        logic [BW-1:0] fab_before;
        exp_t          e;
        int            k;
        fab_before = fab_out;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = v.we; sel = v.sel; adr = v.adr; wdat = v.dat;
        sb_q.push_back('{ack: v.exp_ack, err: v.exp_err, chk_dat: ~v.we, dat: v.exp_rd, stb: v.exp_stb});
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        k = 0;
        while (!(ack | err) && k < 4) begin
            @(posedge clk); #1;
            k++;
        end
        e = sb_q.pop_front();
        if (!(ack | err)) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no termination expected ack=%0b err=%0b", tag, e.ack, e.err);
        end else begin
            check({tag, "_latency"}, BW'(k), BW'(0));
            check({tag, "_ack"}, BW'(ack), BW'(e.ack));
            check({tag, "_err"}, BW'(err), BW'(e.err));
            if (e.chk_dat) check({tag, "_rdat"}, BW'(rdat), BW'(e.dat));
            check({tag, "_stb"}, BW'(fab_stb), BW'(e.stb));
            if (v.lane >= 0) check({tag, "_lane"}, BW'(fab_out[32*v.lane +: 32]), BW'(v.exp_lane));
            else             check({tag, "_fabric"}, fab_out, fab_before);
            @(posedge clk); #1;
            check({tag, "_after"}, BW'({ack, err, fab_stb, rdat}), BW'(0));
        end
    endtask

    initial begin
        logic [5:0] pattern;
        int         acks;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
        for (int i = 0; i < int'(NREGS); i++) fab_in[32*i +: 32] = 32'h1111_1111 * i;
        fab_in[32 +: 32] = 32'hCAFE_F00D;

        // Table: regs 0..3 RO, 4..7 RW
        vecs[0]  = mk(1, 4'hE, 32'h10, 32'hEEEE_EEEE, 1, 0, 0, 8'h10, 4, 32'hEEEE_EE00);
        vecs[1]  = mk(0, 4'hF, 32'h10, 32'h0,         1, 0, 32'hEEEE_EE00, 8'h00, -1, 0);
        vecs[2]  = mk(1, 4'hF, 32'h14, 32'h1234_5678, 1, 0, 0, 8'h20, 5, 32'h1234_5678);
        vecs[3]  = mk(1, 4'h5, 32'h14, 32'hAABB_CCDD, 1, 0, 0, 8'h20, 5, 32'h12BB_56DD);
        vecs[4]  = mk(0, 4'h0, 32'h14, 32'h0,         1, 0, 32'h12BB_56DD, 8'h00, -1, 0);
        vecs[5]  = mk(1, 4'h0, 32'h1C, 32'hFFFF_FFFF, 1, 0, 0, 8'h80, 7, 32'h0);
        vecs[6]  = mk(0, 4'hF, 32'h04, 32'h0,         1, 0, 32'hCAFE_F00D, 8'h00, -1, 0);
        vecs[7]  = mk(0, 4'hF, 32'h06, 32'h0,         1, 0, 32'hCAFE_F00D, 8'h00, -1, 0);
        vecs[8]  = mk(0, 4'hF, 32'h0F, 32'h0,         1, 0, 32'h3333_3333, 8'h00, -1, 0);
        vecs[9]  = mk(1, 4'hF, 32'h20, 32'h5555_5555, ~ERR_EN, ERR_EN, 0, 8'h00, -1, 0);
        vecs[10] = mk(1, 4'hF, 32'h00, 32'hDEAD_BEEF, ~ERR_EN, ERR_EN, 0, 8'h00, -1, 0);
        vecs[11] = mk(0, 4'hF, 32'h20, 32'h0,         ~ERR_EN, ERR_EN, 0, 8'h00, -1, 0);
        vecs[12] = mk(0, 4'hF, 32'h0001_0010, 32'h0,  ~ERR_EN, ERR_EN, 0, 8'h00, -1, 0);
        vecs[13] = mk(0, 4'hF, 32'h18, 32'h0,         1, 0, 32'h0, 8'h00, -1, 0);
        vecs[14] = mk(1, 4'h1, 32'h1F, 32'h0000_0001, 1, 0, 0, 8'h80, 7, 32'h0000_0001);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_term", BW'({ack, err}), BW'(0));
        check("reset_rdat", BW'(rdat), BW'(0));
        check("reset_stb", BW'(fab_stb), BW'(0));
        check("reset_fabric", fab_out, BW'(0));
        rst = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Fabric change then a read two cycles later sees the new capture.
        @(negedge clk);
        fab_in[64 +: 32] = 32'h1357_9BDF;
        run_vec(mk(0, 4'hF, 32'h08, 32'h0, 1, 0, 32'h1357_9BDF, 8'h00, -1, 0), "ro_update");

        // Held strobe: one access every second cycle.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h14; sel = 4'hF;
        pattern = '0; acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            pattern[c] = ack;
            if (ack) begin
                acks++;
                check("held_rdat", BW'(rdat), BW'(32'h12BB_56DD));
            end
            check("held_err", BW'(err), BW'(0));
        end
        cyc = 1'b0; stb = 1'b0;
        check("held_count", BW'(acks), BW'(3));
        check("held_pattern", BW'(pattern), BW'(6'b010101));
        @(posedge clk); #1;
        check("held_after", BW'({ack, err}), BW'(0));

        // cyc low: strobe alone is ignored.
        @(negedge clk);
        cyc = 1'b0; stb = 1'b1; we = 1'b1; adr = 32'h10; wdat = 32'h0; sel = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("nocyc_term", BW'({ack, err, fab_stb}), BW'(0));
        end
        stb = 1'b0;
        check("nocyc_lane4", BW'(fab_out[128 +: 32]), BW'(32'hEEEE_EE00));

        // Reset in the request cycle discards the access.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h18; wdat = 32'hDEAD_BEEF; sel = 4'hF;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("rstmid_term", BW'({ack, err, fab_stb}), BW'(0));
            @(posedge clk); #1;
        end
        check("rstmid_lane6", BW'(fab_out[192 +: 32]), BW'(0));
        check("rstmid_lane4", BW'(fab_out[128 +: 32]), BW'(0));
        run_vec(mk(1, 4'hF, 32'h18, 32'hDEAD_BEEF, 1, 0, 0, 8'h40, 6, 32'hDEAD_BEEF), "retry");
        run_vec(mk(0, 4'hF, 32'h04, 32'h0, 1, 0, 32'hCAFE_F00D, 8'h00, -1, 0), "ro_after_rst");

        check("sb_empty", BW'(sb_q.size()), BW'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
